// File: rtl/sched_pkg.sv
// Shared constants, FSM state type and opcode classification for the dual-issue scheduler.
package sched_pkg;

   localparam int unsigned NREGS = 16;
   localparam int unsigned REG_W = 4;
   localparam int unsigned OP_W  = 4;

   localparam logic [OP_W-1:0] OP_LD  = 4'b1100;
   localparam logic [OP_W-1:0] OP_ST  = 4'b1101;
   localparam logic [OP_W-1:0] OP_BEQ = 4'b1110;
   localparam logic [OP_W-1:0] OP_JMP = 4'b1111;

   typedef enum logic {
      StRun,
      StL1Pend
   } sched_state_e;

   function automatic logic is_mem(input logic [OP_W-1:0] op);
      return (op == OP_LD) || (op == OP_ST);
   endfunction

   function automatic logic writes_rd(input logic [OP_W-1:0] op);
      return !((op == OP_ST) || (op == OP_BEQ) || (op == OP_JMP));
   endfunction

endpackage

// File: rtl/scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set wins over clear.
module scoreboard
   import sched_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr0_en,
   input  logic [REG_W-1:0] clr0_reg,
   input  logic             clr1_en,
   input  logic [REG_W-1:0] clr1_reg,
   input  logic             set0_en,
   input  logic [REG_W-1:0] set0_reg,
   input  logic             set1_en,
   input  logic [REG_W-1:0] set1_reg,
   output logic [NREGS-1:0] busy_vec
);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [NREGS-1:0] clr_mask, set_mask;

   always_comb begin
      clr_mask = '0;
      set_mask = '0;
      if (clr0_en) clr_mask[clr0_reg] = 1'b1;
      if (clr1_en) clr_mask[clr1_reg] = 1'b1;
      if (set0_en) set_mask[set0_reg] = 1'b1;
      if (set1_en) set_mask[set1_reg] = 1'b1;
      // A new writer issued this cycle must stay tracked even if an older write retires.
      busy_d = (busy_q & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue controller: hazard checks against the scoreboard, pair sequencing,
// decode stall and branch flush.
module dual_issue_scheduler
   import sched_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             is_branch_taken,
   input  logic             ex_ready,
   input  logic             in0_valid,
   input  logic [OP_W-1:0]  in0_opcode,
   input  logic [REG_W-1:0] in0_rd,
   input  logic [REG_W-1:0] in0_rs1,
   input  logic [REG_W-1:0] in0_rs2,
   input  logic             in0_imm_flag,
   input  logic             in1_valid,
   input  logic [OP_W-1:0]  in1_opcode,
   input  logic [REG_W-1:0] in1_rd,
   input  logic [REG_W-1:0] in1_rs1,
   input  logic [REG_W-1:0] in1_rs2,
   input  logic             in1_imm_flag,
   input  logic             wb0_en,
   input  logic [REG_W-1:0] wb0_reg,
   input  logic             wb1_en,
   input  logic [REG_W-1:0] wb1_reg,
   output logic             issue0,
   output logic             issue1,
   output logic             stall,
   output logic [NREGS-1:0] busy_vec
);

   sched_state_e state_q, state_d;
   logic         haz0, haz1, pairconf, go;

   function automatic logic hazard(input logic [NREGS-1:0] busy, input logic [OP_W-1:0] op,
                                   input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                                   input logic [REG_W-1:0] rs2, input logic imm);
      return busy[rs1] | (!imm & busy[rs2]) | (writes_rd(op) & busy[rd]);
   endfunction

   always_comb begin
      haz0 = hazard(busy_vec, in0_opcode, in0_rd, in0_rs1, in0_rs2, in0_imm_flag);
      haz1 = hazard(busy_vec, in1_opcode, in1_rd, in1_rs1, in1_rs2, in1_imm_flag);
      pairconf = (writes_rd(in0_opcode) &
                  ((in1_rs1 == in0_rd) | (!in1_imm_flag & (in1_rs2 == in0_rd))))
               | (writes_rd(in0_opcode) & writes_rd(in1_opcode) & (in0_rd == in1_rd))
               | (is_mem(in0_opcode) & is_mem(in1_opcode));
      go      = ex_ready & !is_branch_taken & reset;
      issue0  = 1'b0;
      issue1  = 1'b0;
      stall   = 1'b0;
      state_d = state_q;
      unique case (state_q)
         StRun: begin
            issue0 = in0_valid & go & !haz0;
            issue1 = issue0 & in1_valid & !haz1 & !pairconf;
            stall  = (in0_valid & !issue0) | (in1_valid & !issue1);
            if (issue0 & in1_valid & !issue1) state_d = StL1Pend;
         end
         StL1Pend: begin
            issue1 = in1_valid & go & !haz1;
            stall  = !issue1;
            if (issue1) state_d = StRun;
         end
         default: state_d = StRun;
      endcase
      // A redirect discards the pair, so decode must not be held.
      if (is_branch_taken || !reset) begin
         stall   = 1'b0;
         state_d = StRun;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   scoreboard u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .clr0_en  (wb0_en),
      .clr0_reg (wb0_reg),
      .clr1_en  (wb1_en),
      .clr1_reg (wb1_reg),
      .set0_en  (issue0 & writes_rd(in0_opcode)),
      .set0_reg (in0_rd),
      .set1_en  (issue1 & writes_rd(in1_opcode)),
      .set1_reg (in1_rd),
      .busy_vec (busy_vec)
   );

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard-style bench: stimulus pushes model expectations, a negedge monitor compares.
module tb_dual_issue_scheduler;
   import sched_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, is_branch_taken, ex_ready;
   logic        in0_valid, in0_imm_flag, in1_valid, in1_imm_flag;
   logic [3:0]  in0_opcode, in0_rd, in0_rs1, in0_rs2;
   logic [3:0]  in1_opcode, in1_rd, in1_rs1, in1_rs2;
   logic        wb0_en, wb1_en;
   logic [3:0]  wb0_reg, wb1_reg;
   logic        issue0, issue1, stall;
   logic [15:0] busy_vec;

   dual_issue_scheduler dut (
      .clk(clk), .reset(reset), .is_branch_taken(is_branch_taken), .ex_ready(ex_ready),
      .in0_valid(in0_valid), .in0_opcode(in0_opcode), .in0_rd(in0_rd), .in0_rs1(in0_rs1),
      .in0_rs2(in0_rs2), .in0_imm_flag(in0_imm_flag),
      .in1_valid(in1_valid), .in1_opcode(in1_opcode), .in1_rd(in1_rd), .in1_rs1(in1_rs1),
      .in1_rs2(in1_rs2), .in1_imm_flag(in1_imm_flag),
      .wb0_en(wb0_en), .wb0_reg(wb0_reg), .wb1_en(wb1_en), .wb1_reg(wb1_reg),
      .issue0(issue0), .issue1(issue1), .stall(stall), .busy_vec(busy_vec)
   );

   typedef struct {
      bit       rst_n, br, rdy, v0, v1, imm0, imm1, w0, w1;
      bit [3:0] op0, rd0, a0, b0, op1, rd1, a1, b1, wr0, wr1;
   } stim_t;

   typedef struct {
      bit        i0, i1, st;
      bit [15:0] busy;
      int        cyc;
   } exp_t;

   exp_t expq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   m_busy[16];
   bit   m_pend = 1'b0;
   bit   last_stall = 1'b0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v,
                      input int c);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp_v);
      end
   endtask

   // Opcode classes straight from the ISA table.
   function automatic bit m_writes(input bit [3:0] op);
      return !(op inside {4'b1101, 4'b1110, 4'b1111});
   endfunction

   function automatic bit m_mem(input bit [3:0] op);
      return op inside {4'b1100, 4'b1101};
   endfunction

   // True when any register the instruction touches still has a write outstanding.
   function automatic bit m_blocked(input bit [3:0] op, input bit [3:0] rd, input bit [3:0] a,
                                    input bit [3:0] b, input bit imm);
      bit [3:0] used[$];
      used.push_back(a);
      if (!imm) used.push_back(b);
      if (m_writes(op)) used.push_back(rd);
      foreach (used[k]) if (m_busy[used[k]]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      s.rst_n = 1'b1;
      s.rdy   = 1'b1;
      return s;
   endfunction

   task automatic step(input stim_t s);
      exp_t e;
      bit   g0, g1, conf;
      @(posedge clk);
      #1;
      cyc++;
      reset = s.rst_n; is_branch_taken = s.br; ex_ready = s.rdy;
      in0_valid = s.v0; in0_opcode = s.op0; in0_rd = s.rd0; in0_rs1 = s.a0; in0_rs2 = s.b0;
      in0_imm_flag = s.imm0;
      in1_valid = s.v1; in1_opcode = s.op1; in1_rd = s.rd1; in1_rs1 = s.a1; in1_rs2 = s.b1;
      in1_imm_flag = s.imm1;
      wb0_en = s.w0; wb0_reg = s.wr0; wb1_en = s.w1; wb1_reg = s.wr1;
      for (int r = 0; r < 16; r++) e.busy[r] = m_busy[r];
      g0 = 1'b0;
      g1 = 1'b0;
      if (s.rst_n && !s.br && s.rdy) begin
         if (!m_pend) begin
            conf = (m_writes(s.op0) && (s.a1 == s.rd0 || (!s.imm1 && s.b1 == s.rd0)))
                || (m_writes(s.op0) && m_writes(s.op1) && s.rd0 == s.rd1)
                || (m_mem(s.op0) && m_mem(s.op1));
            g0 = s.v0 && !m_blocked(s.op0, s.rd0, s.a0, s.b0, s.imm0);
            g1 = g0 && s.v1 && !conf && !m_blocked(s.op1, s.rd1, s.a1, s.b1, s.imm1);
         end else begin
            g1 = s.v1 && !m_blocked(s.op1, s.rd1, s.a1, s.b1, s.imm1);
         end
      end
      e.i0  = g0;
      e.i1  = g1;
      e.st  = (!s.rst_n || s.br) ? 1'b0 : (m_pend ? !g1 : ((s.v0 && !g0) || (s.v1 && !g1)));
      e.cyc = cyc;
      expq.push_back(e);
      last_stall = e.st;
      if (!s.rst_n) begin
         foreach (m_busy[r]) m_busy[r] = 1'b0;
         m_pend = 1'b0;
      end else begin
         if (s.w0) m_busy[s.wr0] = 1'b0;
         if (s.w1) m_busy[s.wr1] = 1'b0;
         if (g0 && m_writes(s.op0)) m_busy[s.rd0] = 1'b1;
         if (g1 && m_writes(s.op1)) m_busy[s.rd1] = 1'b1;
         if (s.br) m_pend = 1'b0;
         else if (m_pend) m_pend = !g1;
         else m_pend = g0 && s.v1 && !g1;
      end
   endtask

   task automatic set_pair(inout stim_t s, input bit [3:0] op0, input bit [3:0] rd0,
                           input bit [3:0] a0, input bit [3:0] b0, input bit [3:0] op1,
                           input bit [3:0] rd1, input bit [3:0] a1, input bit [3:0] b1);
      s.v0 = 1'b1; s.op0 = op0; s.rd0 = rd0; s.a0 = a0; s.b0 = b0;
      s.v1 = 1'b1; s.op1 = op1; s.rd1 = rd1; s.a1 = a1; s.b1 = b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("issue0", {15'd0, issue0}, {15'd0, e.i0}, e.cyc);
         chk("issue1", {15'd0, issue1}, {15'd0, e.i1}, e.cyc);
         chk("stall", {15'd0, stall}, {15'd0, e.st}, e.cyc);
         chk("busy_vec", busy_vec, e.busy, e.cyc);
      end
   end

   initial begin
      stim_t s;
      bit    keep;
      s = idle();
      s.rst_n = 1'b0;
      reset = 1'b0; is_branch_taken = 1'b0; ex_ready = 1'b0;
      in0_valid = 1'b0; in0_opcode = '0; in0_rd = '0; in0_rs1 = '0; in0_rs2 = '0;
      in0_imm_flag = 1'b0;
      in1_valid = 1'b0; in1_opcode = '0; in1_rd = '0; in1_rs1 = '0; in1_rs2 = '0;
      in1_imm_flag = 1'b0;
      wb0_en = 1'b0; wb0_reg = '0; wb1_en = 1'b0; wb1_reg = '0;
      step(s);
      step(s);

      // Independent pair dual-issues.
      s = idle(); set_pair(s, 4'h1, 4'd1, 4'd2, 4'd3, 4'h1, 4'd4, 4'd5, 4'd6); step(s);
      s = idle(); step(s);
      chk("busy_after_pair", busy_vec, 16'h0012, cyc);
      s = idle(); s.w0 = 1; s.wr0 = 4'd1; s.w1 = 1; s.wr1 = 4'd4; step(s);

      // Intra-pair RAW: lane 1 waits until the writeback has been registered.
      s = idle(); set_pair(s, 4'h1, 4'd3, 4'd8, 4'd9, 4'h1, 4'd10, 4'd3, 4'd11);
      step(s);
      step(s);
      s.w0 = 1; s.wr0 = 4'd3; step(s);
      s.w0 = 0; step(s);
      s = idle(); s.w0 = 1; s.wr0 = 4'd10; step(s);

      // Two loads share the memory port.
      s = idle(); set_pair(s, 4'hC, 4'd1, 4'd5, 4'd6, 4'hC, 4'd2, 4'd7, 4'd8);
      step(s);
      step(s);
      s = idle(); s.w0 = 1; s.wr0 = 4'd1; s.w1 = 1; s.wr1 = 4'd2; step(s);

      // Same-cycle writeback and new writer of r7.
      s = idle(); s.v0 = 1; s.op0 = 4'h1; s.rd0 = 4'd7; s.w0 = 1; s.wr0 = 4'd7; step(s);
      s = idle(); step(s);
      chk("busy7_set_wins", {15'd0, busy_vec[7]}, 16'd1, cyc);
      s = idle(); s.w0 = 1; s.wr0 = 4'd7; step(s);

      // Branch while lane 1 is pending.
      s = idle(); set_pair(s, 4'h1, 4'd3, 4'd8, 4'd9, 4'h1, 4'd10, 4'd3, 4'd11);
      step(s);
      s.br = 1; step(s);
      s = idle(); step(s);
      s = idle(); s.w0 = 1; s.wr0 = 4'd3; step(s);

      // Execute not ready, then reset while lane 1 is pending.
      s = idle(); set_pair(s, 4'h1, 4'd12, 4'd0, 4'd0, 4'h1, 4'd13, 4'd0, 4'd0);
      s.rdy = 0; step(s);
      s = idle(); set_pair(s, 4'h1, 4'd5, 4'd8, 4'd9, 4'h1, 4'd6, 4'd5, 4'd11);
      step(s);
      s.rst_n = 0; step(s);
      s = idle(); step(s);
      chk("busy_after_reset", busy_vec, 16'h0000, cyc);

      // Randomized traffic with decode holding its pair while stalled.
      keep = 1'b0;
      s = idle();
      for (int n = 0; n < 3000; n++) begin
         if (!keep) begin
            s.v0 = ($urandom_range(99) < 85); s.v1 = ($urandom_range(99) < 85);
            s.op0 = 4'($urandom_range(15)); s.op1 = 4'($urandom_range(15));
            s.rd0 = 4'($urandom_range(7)); s.a0 = 4'($urandom_range(7));
            s.b0 = 4'($urandom_range(7)); s.rd1 = 4'($urandom_range(7));
            s.a1 = 4'($urandom_range(7)); s.b1 = 4'($urandom_range(7));
            s.imm0 = 1'($urandom_range(1)); s.imm1 = 1'($urandom_range(1));
         end
         s.rst_n = ($urandom_range(99) >= 2);
         s.br    = ($urandom_range(99) < 5);
         s.rdy   = ($urandom_range(99) < 80);
         s.w0 = ($urandom_range(99) < 60); s.wr0 = 4'($urandom_range(7));
         s.w1 = ($urandom_range(99) < 30); s.wr1 = 4'($urandom_range(7));
         step(s);
         keep = last_stall;
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- In-order dual-issue controller between the two decode lanes and the execute stage.
- Tracks pending destination registers with a 16-entry scoreboard.
- Sequences each decoded pair into execute, detecting intra-pair RAW/WAW hazards and shared memory-port conflicts.
- Drives `stall` back to decode/fetch and aborts pending issue on `is_branch_taken`.

Parameters:
- NREGS, 16, architectural register count (4-bit register fields).
- REG_W, 4, register index width.
- OP_W, 4, opcode width (instr[15:12]).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- is_branch_taken  in  1  execute-stage redirect; flushes the current pair.
- ex_ready  in  1  execute can accept instructions this cycle.
- in0_valid / in1_valid  in  1  decode lane 0 (older) / lane 1 (younger) holds an instruction.
- in0_opcode / in1_opcode  in  4  lane opcode.
- in0_rd, in0_rs1, in0_rs2 / in1_rd, in1_rs1, in1_rs2  in  4  lane register fields.
- in0_imm_flag / in1_imm_flag  in  1  1 = immediate form, so rs2 is not read.
- wb0_en, wb1_en  in  1  writeback port valid.
- wb0_reg, wb1_reg  in  4  writeback destination register.
- issue0  out  1  lane 0 is dispatched this cycle.
- issue1  out  1  lane 1 is dispatched this cycle.
- stall  out  1  decode must hold its current pair.
- busy_vec  out  16  scoreboard state, bit r = register r has a pending write.

Behaviour:
- Opcode classes (package function):
  - mem = OP_LD (4'b1100) or OP_ST (4'b1101).
  - writes_rd = every opcode except OP_ST, OP_BEQ (4'b1110) and OP_JMP (4'b1111).
  - reads_rs2 = !imm_flag.
- Reset (reset==0 at a posedge):
  - state=RUN, busy_vec=0.
  - While reset is low, issue0=issue1=0 and stall=0.
- States:
  - RUN: both lanes are pending.
  - L1_PEND: lane 0 has already issued; lane 1 is still waiting.
- hazard(lane), evaluated against registered busy_vec:
  - busy[rs1], or
  - busy[rs2] when reads_rs2, or
  - busy[rd] when writes_rd (WAW).
  - There is no bypass: a writeback at edge N clears busy, and the register becomes usable for issue in cycle N+1.
- RUN issue rules (combinational from inputs and state):
  - issue0 = in0_valid & ex_ready & !is_branch_taken & !hazard(0).
  - issue1 = issue0 & in1_valid & !hazard(1) & !pairconf.
  - pairconf is any of:
    - lane0 writes_rd and in1 reads in0_rd (rs1, or rs2 when read);
    - both lanes writes_rd with equal rd;
    - both lanes mem (single memory port, lane 0 wins).
- L1_PEND issue rules:
  - issue0 = 0.
  - issue1 = in1_valid & ex_ready & !is_branch_taken & !hazard(1).
- stall = valid pair not fully consumed this cycle:
  - RUN: (in0_valid & !issue0) | (in1_valid & !issue1).
  - L1_PEND: !issue1.
  - Forced to 0 when is_branch_taken=1.
- Transitions:
  - RUN→L1_PEND when issue0 & in1_valid & !issue1.
  - L1_PEND→RUN when issue1.
  - is_branch_taken=1 in any state: next state is RUN, and no issue occurs that cycle.
- Scoreboard update per posedge:
  - Clear busy[wbX_reg] for each wbX_en.
  - Then set busy[rd] for each issued lane with writes_rd.
  - Set wins over clear on the same register in the same cycle.
  - Writeback to a non-busy register is ignored.
  - wb0 and wb1 to the same register is legal: single clear.
- is_branch_taken does not clear busy_vec; in-flight writes still retire.
- in0_valid=0 in RUN: lane 1 is never issued alone (in-order); stall follows in1_valid.
- Reset mid-L1_PEND: returns to RUN, drops the pending lane 1, clears busy_vec.

Decomposition:
- Shared package `sched_pkg`:
  - Constants OP_LD, OP_ST, OP_BEQ, OP_JMP, NREGS, REG_W.
  - Functions is_mem(op) and writes_rd(op).
- One sub-module `scoreboard`:
  - 16-bit busy register.
  - Two clear ports and two set ports, with set-over-clear priority.
  - Read-out vector.
- The FSM and issue logic stay in the top.

Test Plan:
- Independent pair (lane0 op 4'b0001 rd=1 rs=2,3; lane1 op 4'b0001 rd=4 rs=5,6), ex_ready=1, busy_vec=0 → issue0=issue1=1, stall=0, busy_vec=16'h0012 next cycle.
- Intra-pair RAW (lane0 rd=3; lane1 rs1=3) → cycle 1: issue0=1, issue1=0, stall=1, state L1_PEND. Cycle 2 (busy[3]=1, no wb): issue1=0, stall=1. Pulse wb0_en reg 3 → next cycle issue1=1, stall=0, state RUN.
- Both lanes OP_LD with independent registers → issue0=1 then, next cycle, issue1=1; stall=1 for exactly one cycle.
- Same-cycle wb0 reg 7 and lane0 issue with rd=7 (busy[7] initially 0) → busy[7]=1 after the edge.
- In L1_PEND, assert is_branch_taken → issue1=0, stall=0, next state RUN; busy_vec unchanged.
- ex_ready=0 with a valid pair → issue0=issue1=0, stall=1; reset=0 during L1_PEND → busy_vec=0, state RUN next cycle.
